pe_bypass_ctrl: RTL

- Hazard/forwarding controller on the IF side of the PE pipeline (IF -> ID -> EX1 -> EX2/WB).
- Tracks destination registers of in-flight instructions and produces the registered bypass flags and source selects that the PE bypass network consumes in ID.
- Issues a one-cycle interlock when a 2-cycle unit (MUL, LSU) result is needed by the instruction that directly follows it.
- Counts interlock cycles for profiling.

---
 rtl/pe_bypass_ctrl_pkg.sv | 28 ++
 rtl/pe_bypass_ctrl_match.sv | 45 ++++
 rtl/pe_bypass_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/pe_bypass_ctrl_pkg.sv
// Shared PE definitions: register index width, bypass source encodings,
// the in-flight slot record and the multicycle-unit predicate.
`default_nettype none

package pe_bypass_ctrl_pkg;

   localparam int DEF_RF_INDEX_WIDTH = 5;

   localparam logic [1:0] RISC24_BYPASS_SRC_ALU    = 2'd0;
   localparam logic [1:0] RISC24_BYPASS_SRC_MUL    = 2'd1;
   localparam logic [1:0] RISC24_BYPASS_SRC_LSU    = 2'd2;
   localparam logic [1:0] RISC24_BYPASS_SRC_SHADOW = 2'd3;

   typedef struct packed {
      logic                          valid;
      logic                          writes;
      logic [DEF_RF_INDEX_WIDTH-1:0] dest;
      logic [1:0]                    unit;
   } slot_t;

   // MUL and LSU results appear one cycle later than ALU/SHADOW results.
   function automatic logic risc24_unit_is_multicycle(input logic [1:0] unit);
      return (unit == RISC24_BYPASS_SRC_MUL) || (unit == RISC24_BYPASS_SRC_LSU);
   endfunction

endpackage

`default_nettype wire

// File: rtl/pe_bypass_ctrl_match.sv
// Per-source-port hazard resolution against the ID and EX1 tracking slots.
`default_nettype none

module pe_bypass_ctrl_match
   import pe_bypass_ctrl_pkg::*;
(
   input  logic [DEF_RF_INDEX_WIDTH-1:0] addr,
   input  logic                          enable,
   input  slot_t                         id_slot,
   input  slot_t                         ex1_slot,
   output logic                          read,
   output logic [1:0]                    sel,
   output logic                          stall_req
);

   logic addr_real;
   logic id_hit;
   logic ex1_hit;

   // r0 and r1 are hard-wired and never forwarded.
   assign addr_real = enable && (addr > DEF_RF_INDEX_WIDTH'(1));
   assign id_hit    = addr_real && id_slot.valid && id_slot.writes && (id_slot.dest == addr);
   assign ex1_hit   = addr_real && ex1_slot.valid && ex1_slot.writes && (ex1_slot.dest == addr);

   always_comb begin
      read      = 1'b0;
      sel       = RISC24_BYPASS_SRC_ALU;
      stall_req = 1'b0;
      if (id_hit) begin
         if (risc24_unit_is_multicycle(id_slot.unit)) begin
            stall_req = 1'b1;
         end else begin
            read = 1'b1;
            sel  = id_slot.unit;
         end
      end else if (ex1_hit && risc24_unit_is_multicycle(ex1_slot.unit)) begin
         // Single-cycle EX1 producers are covered by the network's WB bypass.
         read = 1'b1;
         sel  = ex1_slot.unit;
      end
   end

endmodule

`default_nettype wire

// File: rtl/pe_bypass_ctrl.sv
// IF-side hazard/forwarding controller: tracks in-flight destinations,
// registers bypass flags/selects for ID and raises a one-cycle interlock.
`default_nettype none

module pe_bypass_ctrl
   import pe_bypass_ctrl_pkg::*;
#(
   parameter int RF_IDX_W = DEF_RF_INDEX_WIDTH,
   parameter int CNT_W    = 16
) (
   input  logic                iClk,
   input  logic                iReset_n,
   input  logic                iIF_Valid,
   input  logic [RF_IDX_W-1:0] iIF_RF_Read_Addr_A,
   input  logic [RF_IDX_W-1:0] iIF_RF_Read_Addr_B,
   input  logic                iIF_Uses_B,
   input  logic                iIF_Writes_RF,
   input  logic [RF_IDX_W-1:0] iIF_Dest_Addr,
   input  logic [1:0]          iIF_Dest_Unit,
   input  logic                iFreeze,
   input  logic                iFlush,
   output logic                oBP_Stall,
   output logic                oBP_Bypass_Read_A,
   output logic                oBP_Bypass_Read_B,
   output logic [1:0]          oBP_Bypass_Sel_A,
   output logic [1:0]          oBP_Bypass_Sel_B,
   output logic [CNT_W-1:0]    oBP_Stall_Count
);

   localparam slot_t BUBBLE = '0;

   slot_t       id_slot;
   slot_t       ex1_slot;
   slot_t       if_slot;
   logic        read_a;
   logic        read_b;
   logic [1:0]  sel_a;
   logic [1:0]  sel_b;
   logic        stall_req_a;
   logic        stall_req_b;
   logic        kill_id;

   assign if_slot.valid  = iIF_Valid;
   assign if_slot.writes = iIF_Writes_RF;
   assign if_slot.dest   = iIF_Dest_Addr;
   assign if_slot.unit   = iIF_Dest_Unit;

   pe_bypass_ctrl_match u_match_a (
      .addr      (iIF_RF_Read_Addr_A),
      .enable    (1'b1),
      .id_slot   (id_slot),
      .ex1_slot  (ex1_slot),
      .read      (read_a),
      .sel       (sel_a),
      .stall_req (stall_req_a)
   );

   pe_bypass_ctrl_match u_match_b (
      .addr      (iIF_RF_Read_Addr_B),
      .enable    (iIF_Uses_B),
      .id_slot   (id_slot),
      .ex1_slot  (ex1_slot),
      .read      (read_b),
      .sel       (sel_b),
      .stall_req (stall_req_b)
   );

   // A flush squashes the hazard, so no interlock is raised against it.
   assign oBP_Stall = iIF_Valid && (stall_req_a || stall_req_b) && !iFlush;
   assign kill_id   = iFlush || oBP_Stall || !iIF_Valid;

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         id_slot           <= BUBBLE;
         ex1_slot          <= BUBBLE;
         oBP_Bypass_Read_A <= 1'b0;
         oBP_Bypass_Read_B <= 1'b0;
         oBP_Bypass_Sel_A  <= RISC24_BYPASS_SRC_ALU;
         oBP_Bypass_Sel_B  <= RISC24_BYPASS_SRC_ALU;
         oBP_Stall_Count   <= '0;
      end else if (!iFreeze) begin
         ex1_slot <= iFlush ? BUBBLE : id_slot;
         id_slot  <= kill_id ? BUBBLE : if_slot;
         if (kill_id) begin
            oBP_Bypass_Read_A <= 1'b0;
            oBP_Bypass_Read_B <= 1'b0;
            oBP_Bypass_Sel_A  <= RISC24_BYPASS_SRC_ALU;
            oBP_Bypass_Sel_B  <= RISC24_BYPASS_SRC_ALU;
         end else begin
            oBP_Bypass_Read_A <= read_a;
            oBP_Bypass_Read_B <= read_b;
            oBP_Bypass_Sel_A  <= sel_a;
            oBP_Bypass_Sel_B  <= sel_b;
         end
         if (oBP_Stall && !iFlush && !(&oBP_Stall_Count)) begin
            oBP_Stall_Count <= oBP_Stall_Count + CNT_W'(1);
         end
      end
   end

endmodule

`default_nettype wire
